// File: rtl/if_stage.sv
// Purpose : LEGv8 instruction-fetch stage with IF/ID pipeline register and one-entry skid buffer.
// Latency : a word returned with imem_ready appears in IF/ID on the next edge (one per cycle at zero wait).
// Backpr. : stall holds IF/ID; a word arriving under stall parks in the skid and fetch pauses until release.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata  instruction memory handshake (addr is always pc, req only in WAIT)
//   stall, flush, branch_target  hazard-unit hold and taken-branch redirect (flush wins over stall)
//   ifid_valid/pc/instr     IF/ID pipeline register
//   opcode                  instr[31:21] of a live IF/ID entry, zero for a bubble
module if_stage #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,  // must be at least 32 so the opcode field exists
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [10:0]        opcode
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   skid_pc;
  logic [INSTR_W-1:0]  skid_instr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (flush)                    state_nxt = S_WAIT;
        else if (imem_ready && stall) state_nxt = S_HOLD;
        else                          state_nxt = S_WAIT;
      end
      S_HOLD: begin
        if (flush || !stall) state_nxt = S_WAIT;
        else                 state_nxt = S_HOLD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req  = (state == S_WAIT);
    imem_addr = pc;
    opcode    = ifid_valid ? ifid_instr[31:21] : 11'd0;
  end

  // PC, IF/ID register and skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (flush) begin
            // Any word returned this cycle belongs to the squashed path.
            pc         <= branch_target;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
          end else if (imem_ready && !stall) begin
            ifid_pc    <= pc;
            ifid_instr <= imem_rdata;
            ifid_valid <= 1'b1;
            pc         <= pc + ADDR_W'(4);
          end else if (imem_ready && stall) begin
            // Word accepted by memory but ID is frozen: park it, IF/ID untouched.
            skid_pc    <= pc;
            skid_instr <= imem_rdata;
            pc         <= pc + ADDR_W'(4);
          end else if (!stall) begin
            // Bubble: pc/instr keep stale values, masked by valid.
            ifid_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (flush) begin
            pc         <= branch_target;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
          end else if (!stall) begin
            ifid_pc    <= skid_pc;
            ifid_instr <= skid_instr;
            ifid_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               rst_n;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  branch_target;
  logic               ifid_valid;
  logic [ADDR_W-1:0]  ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic [10:0]        opcode;

  if_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .opcode        (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents
  function automatic logic [31:0] word_at(input logic [63:0] a);
    case (a)
      64'd0:   word_at = 32'hF840_0000;
      64'd4:   word_at = 32'h8B02_0020;
      64'd8:   word_at = 32'hB400_0040;
      default: word_at = {8'hC5, a[23:0]};
    endcase
  endfunction

  assign imem_rdata = word_at(imem_addr);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic stall_q   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [63:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = word_at(a);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IF/ID loads a new entry only on an edge where stall was low.
  always @(posedge clk) stall_q <= stall;

  // Monitor: every newly presented live IF/ID entry must match the queue head.
  always @(negedge clk) begin
    if (rst_n && ifid_valid && !stall_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ifid", ifid_pc, 64'hDEAD);
      end else begin
        exp_t e;
        logic [31:0] ei;
        e  = exp_q.pop_front();
        ei = e.instr;
        check("mon_pc", ifid_pc, e.pc);
        check("mon_instr", 64'(ifid_instr), 64'(ei));
        check("mon_opcode", 64'(opcode), 64'(ei[31:21]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = '0;

    // Reset and start-up
    repeat (3) begin
      step();
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_opcode", 64'(opcode), 64'd0);
    end
    check("rst_valid", 64'(ifid_valid), 64'd0);
    rst_n = 1'b1;
    check("idle_req", 64'(imem_req), 64'd0);
    imem_ready = 1'b1;
    step();
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", imem_addr, 64'd0);

    // Streaming, zero-wait memory
    push(64'd0); step();
    check("s0_pc", ifid_pc, 64'd0);
    check("s0_op", 64'(opcode), 64'h7C2);
    push(64'd4); step();
    check("s1_pc", ifid_pc, 64'd4);
    check("s1_op", 64'(opcode), 64'h458);
    push(64'd8); step();
    check("s2_pc", ifid_pc, 64'd8);
    check("s2_op", 64'(opcode), 64'h5A0);

    // Wait states at addr 12
    imem_ready = 1'b0;
    repeat (2) begin
      step();
      check("bub_valid", 64'(ifid_valid), 64'd0);
      check("bub_op", 64'(opcode), 64'd0);
      check("bub_addr", imem_addr, 64'd12);
    end
    imem_ready = 1'b1; push(64'd12); step();
    check("w_pc", ifid_pc, 64'd12);
    check("w_addr", imem_addr, 64'd16);

    // Stall with skid: word at 16 parks while IF/ID holds 12
    stall = 1'b1;
    repeat (3) begin
      step();
      check("stall_req", 64'(imem_req), 64'd0);
      check("stall_pc", ifid_pc, 64'd12);
      check("stall_valid", 64'(ifid_valid), 64'd1);
    end
    stall = 1'b0; imem_ready = 1'b0; push(64'd16); step();
    check("unskid_pc", ifid_pc, 64'd16);
    check("unskid_addr", imem_addr, 64'd20);
    check("unskid_req", 64'(imem_req), 64'd1);

    // Flush in WAIT with a ready word
    imem_ready = 1'b1; flush = 1'b1; branch_target = 64'h100; step();
    check("fl_valid", 64'(ifid_valid), 64'd0);
    check("fl_addr", imem_addr, 64'h100);
    check("fl_op", 64'(opcode), 64'd0);
    flush = 1'b0; push(64'h100); step();
    check("fl_next_pc", ifid_pc, 64'h100);

    // Flush together with stall
    stall = 1'b1; flush = 1'b1; branch_target = 64'h200; step();
    check("fs_valid", 64'(ifid_valid), 64'd0);
    check("fs_addr", imem_addr, 64'h200);
    check("fs_req", 64'(imem_req), 64'd1);
    stall = 1'b0; flush = 1'b0; push(64'h200); step();
    check("fs_next_pc", ifid_pc, 64'h200);

    // Flush while in HOLD: skid (0x204) must never appear
    stall = 1'b1; step();
    check("h_req", 64'(imem_req), 64'd0);
    flush = 1'b1; branch_target = 64'h300; step();
    check("fh_valid", 64'(ifid_valid), 64'd0);
    check("fh_addr", imem_addr, 64'h300);
    check("fh_req", 64'(imem_req), 64'd1);
    stall = 1'b0; flush = 1'b0; push(64'h300); step();
    check("fh_next_pc", ifid_pc, 64'h300);

    // PC wrap
    imem_ready = 1'b0; flush = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC; step();
    check("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    flush = 1'b0; imem_ready = 1'b1; push(64'hFFFF_FFFF_FFFF_FFFC); step();
    check("wrap_addr1", imem_addr, 64'd0);
    check("wrap_op", 64'(opcode), 64'h62F);

    // Asynchronous reset while in HOLD
    stall = 1'b1; step();
    check("ar_hold_req", 64'(imem_req), 64'd0);
    check("ar_hold_valid", 64'(ifid_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(ifid_valid), 64'd0);
    check("ar_addr", imem_addr, 64'd0);
    check("ar_req", 64'(imem_req), 64'd0);
    check("ar_op", 64'(opcode), 64'd0);
    stall = 1'b0; imem_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("ar_idle_req", 64'(imem_req), 64'd0);
    imem_ready = 1'b1; step();
    check("ar_restart_addr", imem_addr, 64'd0);
    push(64'd0); step();
    check("ar_restart_pc", ifid_pc, 64'd0);
    check("ar_restart_next", imem_addr, 64'd4);
    imem_ready = 1'b0; step();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
